// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter slice.
//   - default memory word-address and data widths
//   - memory operation enum: RV32I load/store width codes, with bit 3
//     separating stores from loads so that every member has a unique value
//   - helpers to split an operation into its funct3 code and store flag
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DM_ADDRESS_DEFAULT = 9;
    localparam int DATA_W_DEFAULT     = 32;

    // Bit 3 marks a store; bits [2:0] are the RV32I funct3 code.
    typedef enum logic [3:0] {
        LB  = 4'b0000,
        LH  = 4'b0001,
        LW  = 4'b0010,
        LBU = 4'b0100,
        LHU = 4'b0101,
        SB  = 4'b1000,
        SH  = 4'b1001,
        SW  = 4'b1010
    } mem_op_e;

    function automatic logic [2:0] op_funct3(input mem_op_e op);
        return op[2:0];
    endfunction

    function automatic logic op_is_store(input mem_op_e op);
        return op[3];
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// One requester port of the data-memory arbiter.
//   master modport (requester): drives req, we, lock, addr, wdata, funct3;
//                               receives gnt, rvalid, rdata
//   slave modport  (arbiter)  : the mirror image
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int DM_ADDRESS = dmem_pkg::DM_ADDRESS_DEFAULT,
    parameter int DATA_W     = dmem_pkg::DATA_W_DEFAULT
);
    logic                  req;
    logic                  we;
    logic                  lock;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic [2:0]            funct3;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, we, lock, addr, wdata, funct3,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata, funct3,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter with grant locking and a starvation limit.
//   clk, rst_n    : clock, asynchronous active-low reset
//   req0, req1    : requests
//   lock0, lock1  : ask to keep the grant for the following cycle
//   gnt0, gnt1    : combinational grants, at most one high, forced low in reset
// A locked owner keeps priority while it requests, until it has taken
// LOCK_MAX consecutive locked grants; then a waiting peer wins once.
// -----------------------------------------------------------------------------
module rr_arbiter2 #(
    parameter int LOCK_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic lock0,
    input  logic lock1,
    output logic gnt0,
    output logic gnt1
);
    localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             ptr_r;          // 1'b0: m0 wins a tie, 1'b1: m1 wins a tie
    logic             lock_active_r;
    logic             lock_owner_r;
    logic [CNT_W-1:0] lock_cnt_r;

    logic owner_req_s;
    logic other_req_s;
    logic expired_s;
    logic any_req_s;
    logic win1_s;
    logic win_lock_s;

    // Winner selection: locked owner, then starvation release, then round robin.
    always_comb begin
        owner_req_s = lock_owner_r ? req1 : req0;
        other_req_s = lock_owner_r ? req0 : req1;
        expired_s   = (lock_cnt_r >= CNT_MAX);
        any_req_s   = req0 | req1;
        win1_s      = 1'b0;
        if (lock_active_r && owner_req_s && !(expired_s && other_req_s)) begin
            win1_s = lock_owner_r;
        end else if (lock_active_r && owner_req_s && expired_s && other_req_s) begin
            win1_s = ~lock_owner_r;
        end else if (req0 && req1) begin
            win1_s = ptr_r;
        end else begin
            win1_s = req1;
        end
        win_lock_s = win1_s ? lock1 : lock0;
        gnt0       = rst_n & any_req_s & ~win1_s;
        gnt1       = rst_n & any_req_s & win1_s;
    end

    // Pointer and lock bookkeeping; the count saturates so it cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r         <= 1'b0;
            lock_active_r <= 1'b0;
            lock_owner_r  <= 1'b0;
            lock_cnt_r    <= {CNT_W{1'b0}};
        end else if (any_req_s) begin
            ptr_r <= ~win1_s;
            if (win_lock_s) begin
                lock_active_r <= 1'b1;
                lock_owner_r  <= win1_s;
                if (lock_active_r && (lock_owner_r == win1_s)) begin
                    lock_cnt_r <= expired_s ? CNT_MAX : (lock_cnt_r + CNT_ONE);
                end else begin
                    lock_cnt_r <= CNT_ONE;
                end
            end else begin
                lock_active_r <= 1'b0;
                lock_cnt_r    <= {CNT_W{1'b0}};
            end
        end else begin
            lock_active_r <= 1'b0;
            lock_cnt_r    <= {CNT_W{1'b0}};
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one data memory between the core load/store unit (m0) and the
// loader/debug port (m1).
//   clk, rst_n        : clock, asynchronous active-low reset
//   m0, m1            : requester ports (dmem_arbiter_if.slave)
//   mem_read/write    : registered memory strobes
//   mem_a, mem_wd     : registered memory address / write data
//   mem_funct3        : registered width code, forwarded unchanged
//   mem_rd            : memory read data, valid while mem_read is high
// Pipeline: grant in N, memory access in N+1, rvalid/rdata in N+2.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = DM_ADDRESS_DEFAULT,
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int LOCK_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_arbiter_if.slave         m0,
    dmem_arbiter_if.slave         m1,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rd
);
    logic gnt0_s;
    logic gnt1_s;
    logic any_gnt_s;

    logic                  sel_we_s;
    logic [DM_ADDRESS-1:0] sel_addr_s;
    logic [DATA_W-1:0]     sel_wdata_s;
    logic [2:0]            sel_funct3_s;

    logic                  mem_read_r;
    logic                  mem_write_r;
    logic [DM_ADDRESS-1:0] mem_a_r;
    logic [DATA_W-1:0]     mem_wd_r;
    logic [2:0]            mem_funct3_r;
    logic                  issue_id_r;    // requester owning the access in flight

    logic                  rvalid0_r;
    logic                  rvalid1_r;
    logic [DATA_W-1:0]     rdata0_r;
    logic [DATA_W-1:0]     rdata1_r;

    rr_arbiter2 #(
        .LOCK_MAX (LOCK_MAX)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (m0.req),
        .req1  (m1.req),
        .lock0 (m0.lock),
        .lock1 (m1.lock),
        .gnt0  (gnt0_s),
        .gnt1  (gnt1_s)
    );

    // Select the granted requester's access fields.
    always_comb begin
        any_gnt_s    = gnt0_s | gnt1_s;
        sel_we_s     = 1'b0;
        sel_addr_s   = {DM_ADDRESS{1'b0}};
        sel_wdata_s  = {DATA_W{1'b0}};
        sel_funct3_s = 3'b000;
        if (gnt1_s) begin
            sel_we_s     = m1.we;
            sel_addr_s   = m1.addr;
            sel_wdata_s  = m1.wdata;
            sel_funct3_s = m1.funct3;
        end else begin
            sel_we_s     = m0.we;
            sel_addr_s   = m0.addr;
            sel_wdata_s  = m0.wdata;
            sel_funct3_s = m0.funct3;
        end
    end

    // Issue stage: register the granted access toward the memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_a_r      <= {DM_ADDRESS{1'b0}};
            mem_wd_r     <= {DATA_W{1'b0}};
            mem_funct3_r <= 3'b000;
            issue_id_r   <= 1'b0;
        end else begin
            mem_read_r  <= any_gnt_s & ~sel_we_s;
            mem_write_r <= any_gnt_s & sel_we_s;
            if (any_gnt_s) begin
                mem_a_r      <= sel_addr_s;
                mem_wd_r     <= sel_wdata_s;
                mem_funct3_r <= sel_funct3_s;
                issue_id_r   <= gnt1_s;
            end
        end
    end

    // Response stage: capture read data and route the pulse to its owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            rdata0_r  <= {DATA_W{1'b0}};
            rdata1_r  <= {DATA_W{1'b0}};
        end else begin
            rvalid0_r <= mem_read_r & ~issue_id_r;
            rvalid1_r <= mem_read_r & issue_id_r;
            if (mem_read_r && !issue_id_r) begin
                rdata0_r <= mem_rd;
            end
            if (mem_read_r && issue_id_r) begin
                rdata1_r <= mem_rd;
            end
        end
    end

    assign m0.gnt     = gnt0_s;
    assign m1.gnt     = gnt1_s;
    assign m0.rvalid  = rvalid0_r;
    assign m1.rvalid  = rvalid1_r;
    assign m0.rdata   = rdata0_r;
    assign m1.rdata   = rdata1_r;
    assign mem_read   = mem_read_r;
    assign mem_write  = mem_write_r;
    assign mem_a      = mem_a_r;
    assign mem_wd     = mem_wd_r;
    assign mem_funct3 = mem_funct3_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed stimulus with a scoreboard: every expected grant pushes the
// expected memory issue and read response; monitors pop them as the DUT
// presents mem strobes and rvalid pulses.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int LM = 8;

    typedef struct {
        int              cyc;
        logic            rd;
        logic            wr;
        logic [AW-1:0]   a;
        logic [DW-1:0]   wd;
        logic [2:0]      f3;
    } iss_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic [2:0]    mem_funct3;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    iss_t iss_q[$];
    rsp_t q0[$];
    rsp_t q1[$];
    iss_t mon_it;
    rsp_t mon_r;

    dmem_arbiter_if #(.DM_ADDRESS(AW), .DATA_W(DW)) m0_if ();
    dmem_arbiter_if #(.DM_ADDRESS(AW), .DATA_W(DW)) m1_if ();

    dmem_arbiter #(
        .DM_ADDRESS (AW),
        .DATA_W     (DW),
        .LOCK_MAX   (LM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0         (m0_if),
        .m1         (m1_if),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_funct3 (mem_funct3),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: word i preloaded with 0x1000_0000 | i, synchronous write.
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000_0000 | 32'(i);
        forever begin
            @(posedge clk);
            if (mem_write) mem[mem_a] <= mem_wd;
        end
    end
    assign mem_rd = mem[mem_a];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set0(input logic r, input logic l, input mem_op_e op,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd);
        m0_if.req = r; m0_if.lock = l; m0_if.we = op_is_store(op);
        m0_if.funct3 = op_funct3(op); m0_if.addr = a; m0_if.wdata = wd;
    endtask

    task automatic set1(input logic r, input logic l, input mem_op_e op,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd);
        m1_if.req = r; m1_if.lock = l; m1_if.we = op_is_store(op);
        m1_if.funct3 = op_funct3(op); m1_if.addr = a; m1_if.wdata = wd;
    endtask

    // One cycle: check grants mid-cycle, queue the expected issue/response.
    task automatic tick(input logic e0, input logic e1, input logic track,
                        input logic [DW-1:0] rexp, input string name);
        iss_t it;
        rsp_t r;
        @(negedge clk);
        check({name, "_gnt"}, {30'd0, m1_if.gnt, m0_if.gnt}, {30'd0, e1, e0});
        if (track && (e0 || e1)) begin
            it.cyc = cyc + 1;
            it.rd  = e1 ? !m1_if.we    : !m0_if.we;
            it.wr  = e1 ? m1_if.we     : m0_if.we;
            it.a   = e1 ? m1_if.addr   : m0_if.addr;
            it.wd  = e1 ? m1_if.wdata  : m0_if.wdata;
            it.f3  = e1 ? m1_if.funct3 : m0_if.funct3;
            iss_q.push_back(it);
            if (it.rd) begin
                r.cyc  = cyc + 2;
                r.data = rexp;
                if (e1) q1.push_back(r);
                else    q0.push_back(r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_zero(input string name);
        @(negedge clk);
        check({name, "_gnt"},    {30'd0, m1_if.gnt, m0_if.gnt}, 32'd0);
        check({name, "_rvalid"}, {30'd0, m1_if.rvalid, m0_if.rvalid}, 32'd0);
        check({name, "_memrw"},  {30'd0, mem_read, mem_write}, 32'd0);
        check({name, "_rdata0"}, m0_if.rdata, 32'd0);
        check({name, "_rdata1"}, m1_if.rdata, 32'd0);
        check({name, "_mem_a"},  {23'd0, mem_a}, 32'd0);
        check({name, "_mem_wd"}, mem_wd, 32'd0);
        check({name, "_f3"},     {29'd0, mem_funct3}, 32'd0);
    endtask

    // Issue monitor: memory strobes must match the queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
                mon_it = iss_q.pop_front();
                check("issue_rd", {31'd0, mem_read},  {31'd0, mon_it.rd});
                check("issue_wr", {31'd0, mem_write}, {31'd0, mon_it.wr});
                check("issue_a",  {23'd0, mem_a},     {23'd0, mon_it.a});
                check("issue_f3", {29'd0, mem_funct3}, {29'd0, mon_it.f3});
                if (mon_it.wr) check("issue_wd", mem_wd, mon_it.wd);
            end else begin
                check("issue_idle", {30'd0, mem_read, mem_write}, 32'd0);
            end
        end
    end

    // Response monitor: each rvalid pops its port's queue.
    always @(negedge clk) begin
        if (rst_n && m0_if.rvalid) begin
            if (q0.size() == 0) begin
                check("rvalid0_unexpected", {31'd0, m0_if.rvalid}, 32'd0);
            end else begin
                mon_r = q0.pop_front();
                check("rvalid0_cycle", 32'(cyc), 32'(mon_r.cyc));
                check("rdata0", m0_if.rdata, mon_r.data);
            end
        end
        if (rst_n && m1_if.rvalid) begin
            if (q1.size() == 0) begin
                check("rvalid1_unexpected", {31'd0, m1_if.rvalid}, 32'd0);
            end else begin
                mon_r = q1.pop_front();
                check("rvalid1_cycle", 32'(cyc), 32'(mon_r.cyc));
                check("rdata1", m1_if.rdata, mon_r.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both requesting: grants must stay low.
        set0(1'b1, 1'b0, LW, 9'h020, 32'd0);
        set1(1'b1, 1'b0, LW, 9'h040, 32'd0);
        check_reset_zero("reset");
        @(posedge clk); #1;
        set0(1'b0, 1'b0, LW, 9'h020, 32'd0);
        set1(1'b0, 1'b0, LW, 9'h040, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Both reading continuously: strict alternation starting with m0.
        set0(1'b1, 1'b0, LW, 9'h020, 32'd0);
        set1(1'b1, 1'b0, LW, 9'h040, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b1, 32'h1000_0020, "rr_m0");
            tick(1'b0, 1'b1, 1'b1, 32'h1000_0040, "rr_m1");
        end
        set0(1'b0, 1'b0, LW, 9'h000, 32'd0);
        set1(1'b0, 1'b0, LW, 9'h000, 32'd0);
        tick(1'b0, 1'b0, 1'b1, 32'd0, "idle_a");

        // Store then load of the same word.
        set0(1'b1, 1'b0, SW, 9'h010, 32'hDEAD_BEEF);
        tick(1'b1, 1'b0, 1'b1, 32'd0, "sw_10");
        set0(1'b1, 1'b0, LW, 9'h010, 32'd0);
        tick(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, "lw_10");

        // Top address, store followed by a byte load.
        set0(1'b1, 1'b0, SW, 9'h1FF, 32'h0000_0055);
        tick(1'b1, 1'b0, 1'b1, 32'd0, "sw_1ff");
        set0(1'b1, 1'b0, LBU, 9'h1FF, 32'd0);
        tick(1'b1, 1'b0, 1'b1, 32'h0000_0055, "lbu_1ff");
        set0(1'b0, 1'b0, LW, 9'h000, 32'd0);
        tick(1'b0, 1'b0, 1'b1, 32'd0, "idle_b");

        // m1 locks for 12 cycles against m0: 8 grants, m0 once, m1 resumes.
        set1(1'b1, 1'b1, LW, 9'h050, 32'd0);
        tick(1'b0, 1'b1, 1'b1, 32'h1000_0050, "lock_first");
        set0(1'b1, 1'b0, LW, 9'h060, 32'd0);
        for (int i = 1; i < LM; i++) tick(1'b0, 1'b1, 1'b1, 32'h1000_0050, "lock_hold");
        tick(1'b1, 1'b0, 1'b1, 32'h1000_0060, "lock_starve");
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 32'h1000_0050, "lock_resume");
        set1(1'b0, 1'b0, LW, 9'h000, 32'd0);
        tick(1'b1, 1'b0, 1'b1, 32'h1000_0060, "lock_drop");
        set0(1'b0, 1'b0, LW, 9'h000, 32'd0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 32'd0, "idle_c");

        // Reset pulse in the cycle after a read grant: the read is dropped.
        set0(1'b1, 1'b0, LW, 9'h070, 32'd0);
        tick(1'b1, 1'b0, 1'b0, 32'd0, "pre_rst");
        rst_n = 1'b0;
        set1(1'b1, 1'b0, LW, 9'h090, 32'd0);
        check_reset_zero("mid_reset");
        @(posedge clk); #1;
        set0(1'b0, 1'b0, LW, 9'h000, 32'd0);
        set1(1'b0, 1'b0, LW, 9'h000, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        set0(1'b1, 1'b0, LW, 9'h080, 32'd0);
        set1(1'b1, 1'b0, LW, 9'h090, 32'd0);
        tick(1'b1, 1'b0, 1'b1, 32'h1000_0080, "post_rst_m0");
        tick(1'b0, 1'b1, 1'b1, 32'h1000_0090, "post_rst_m1");
        set0(1'b0, 1'b0, LW, 9'h000, 32'd0);
        set1(1'b0, 1'b0, LW, 9'h000, 32'd0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, 32'd0, "idle_d");

        check("pending_rsp0", 32'(q0.size()), 32'd0);
        check("pending_rsp1", 32'(q1.size()), 32'd0);
        check("pending_issue", 32'(iss_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
